param_stack: RTL and testbench
==============================

PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 WIDTH, default 16, data word width in bits (>=1).
REQ-002 DEPTH, default 8, number of stack entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; state clears while rst=0.
REQ-005 push  input  1  push Din onto the stack.
REQ-006 pop  input  1  remove the top entry and present it on Dout.
REQ-007 tos  input  1  present the top entry on Dout without removing it.
REQ-008 clr  input  1  synchronous clear of the stack and error flags.
REQ-009 Din  input  WIDTH  data to push.
REQ-010 Dout  output  WIDTH  registered read data.
REQ-011 dvalid  output  1  Dout was updated by a successful read in the previous cycle.
REQ-012 count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-013 full, empty  output  1 each  count==DEPTH and count==0, combinational from count.
REQ-014 ovf, unf  output  1 each  sticky overflow and underflow error flags.

Function
REQ-015 Storage SHALL be DEPTH words of WIDTH bits; the top entry SHALL be mem[count-1].
REQ-016 Command priority per cycle SHALL be clr > (push&pop) > push > pop > tos; lower-priority strobes in the same cycle SHALL be ignored.
REQ-017 clr SHALL set count=0, Dout=0, dvalid=0, ovf=0, unf=0 on the next edge; memory contents are not cleared.
REQ-018 push only, not full: mem[count]<=Din, count+1; Dout held; dvalid=0.
REQ-019 push only, full: no storage or count change; ovf<=1; Dout held; dvalid=0.
REQ-020 pop only, not empty: Dout<=top, count-1, dvalid=1 for exactly the next cycle.
REQ-021 pop only, empty: no change except unf<=1; dvalid=0.
REQ-022 tos only, not empty: Dout<=top, count unchanged, dvalid=1 for the next cycle; when empty: unf<=1, dvalid=0.
REQ-023 push and pop together, not empty (replace): Dout<=old top, top<=Din, count unchanged, dvalid=1; no ovf even when full.
REQ-024 push and pop together, empty: SHALL behave exactly as push only (count becomes 1); unf not set; dvalid=0.
REQ-025 Read latency SHALL be one clock: Dout and dvalid reflect a command sampled on edge N after edge N.
REQ-026 With no strobe asserted, all state SHALL hold and dvalid SHALL be 0.
REQ-027 ovf/unf SHALL remain set until clr or reset; they SHALL NOT block subsequent legal operations.
REQ-028 count SHALL never exceed DEPTH nor go below 0.

Reset
REQ-029 When rst=0: count=0, Dout=0, dvalid=0, ovf=0, unf=0 immediately, independent of clk; memory is not reset.
REQ-030 A command sampled while rst=0 SHALL be discarded; a mid-operation reset SHALL leave the stack empty once rst=1.
REQ-031 The first command SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-032 Defaults WIDTH=16, DEPTH=8 SHALL live in shared package stack_pkg, along with the command priority encoding used by the processor control unit.
REQ-033 Storage SHALL be a sub-module stack_mem (DEPTH x WIDTH register file, one write port, one asynchronous read port addressed by count-1); control, count and flags remain in param_stack.

Verification (bench with WIDTH=16, DEPTH=4)
REQ-034 Reset, then push 0x0001,0x0002,0x0003,0x0004 -> count=4, full=1, ovf=0; a fifth push of 0x0005 -> count=4, ovf=1, top remains 0x0004.
REQ-035 From the REQ-034 state, pop four times -> Dout=0x0004,0x0003,0x0002,0x0001 with dvalid=1 each following cycle, empty=1; a fifth pop -> unf=1, dvalid=0, Dout holds 0x0001.
REQ-036 Push 0x00AA, tos twice -> Dout=0x00AA, dvalid=1 both times, count=1; push and pop with Din=0x00BB -> Dout=0x00AA, count=1; then pop -> Dout=0x00BB, count=0.
REQ-037 Empty stack, push and pop with Din=0x1234 -> count=1, unf=0, dvalid=0; then tos -> Dout=0x1234.
REQ-038 After ovf=1 and unf=1, assert clr with push=1 -> count=0, ovf=0, unf=0, Dout=0, no push performed.
REQ-039 Push 0x0007 twice, drop rst between clock edges -> count=0, Dout=0 without a clock edge; a push of 0x0009 after release -> count=1, top=0x0009.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared stack defaults and the command encoding used by control logic.
// Strobes collapse to one command per cycle in fixed priority order.
package stack_pkg;

  localparam int STACK_WIDTH = 16;
  localparam int STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_TOS,
    CMD_POP,
    CMD_PUSH,
    CMD_REPL,
    CMD_CLR
  } cmd_e;

  function automatic cmd_e cmd_decode(
    input logic clr,
    input logic push,
    input logic pop,
    input logic tos
  );
    cmd_e c;
    c = CMD_NONE;
    if (clr)
      c = CMD_CLR;
    else if (push && pop)
      c = CMD_REPL;
    else if (push)
      c = CMD_PUSH;
    else if (pop)
      c = CMD_POP;
    else if (tos)
      c = CMD_TOS;
    return c;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH register file, one write port,
// one asynchronous read port. Contents are never reset.
module stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// Parameterised LIFO stack with registered read data,
// occupancy count and sticky overflow/underflow flags.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       tos,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           Din,
  output logic [WIDTH-1:0]           Dout,
  output logic                       dvalid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] MAX = CW'(DEPTH);

  cmd_e             cmd;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] top_data;

  assign cmd      = cmd_decode(clr, push, pop, tos);
  assign top_addr = AW'(cnt_q - ONE);
  assign full     = (cnt_q == MAX);
  assign empty    = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    we     = 1'b0;
    waddr  = cnt_q[AW-1:0];
    unique case (cmd)
      CMD_CLR: begin
        cnt_d  = '0;
        dout_d = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
      end
      CMD_REPL: begin
        // On an empty stack a replace degenerates to a plain push
        if (empty) begin
          we    = 1'b1;
          cnt_d = cnt_q + ONE;
        end else begin
          we     = 1'b1;
          waddr  = top_addr;
          dout_d = top_data;
          dv_d   = 1'b1;
        end
      end
      CMD_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we    = 1'b1;
          cnt_d = cnt_q + ONE;
        end
      end
      CMD_POP: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          dout_d = top_data;
          dv_d   = 1'b1;
          cnt_d  = cnt_q - ONE;
        end
      end
      CMD_TOS: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          dout_d = top_data;
          dv_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we & rst),
    .waddr (waddr),
    .wdata (Din),
    .raddr (top_addr),
    .rdata (top_data)
  );

  assign count  = cnt_q;
  assign Dout   = dout_q;
  assign dvalid = dv_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack at WIDTH=16, DEPTH=4.
// Expected results are queued per command and checked after the edge.
module tb_param_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        tos = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] Din = '0;
  logic [15:0] Dout;
  logic        dvalid;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        unf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [15:0] dout;
    logic        dv;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];

  param_stack #(
    .WIDTH (16),
    .DEPTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .tos    (tos),
    .clr    (clr),
    .Din    (Din),
    .Dout   (Dout),
    .dvalid (dvalid),
    .count  (count),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf),
    .unf    (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input string       tag,
    input logic        pu,
    input logic        po,
    input logic        to,
    input logic        cl,
    input logic [15:0] d,
    input logic [15:0] e_dout,
    input logic        e_dv,
    input logic [2:0]  e_cnt,
    input logic        e_ovf,
    input logic        e_unf
  );
    exp_t e;
    e.tag  = tag;
    e.dout = e_dout;
    e.dv   = e_dv;
    e.cnt  = e_cnt;
    e.ovf  = e_ovf;
    e.unf  = e_unf;
    sb.push_back(e);
    push = pu;
    pop  = po;
    tos  = to;
    clr  = cl;
    Din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    tos  = 1'b0;
    clr  = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_dout"}, 32'(Dout), 32'(e.dout));
      chk({e.tag, "_dv"}, 32'(dvalid), 32'(e.dv));
      chk({e.tag, "_cnt"}, 32'(count), 32'(e.cnt));
      chk({e.tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
      chk({e.tag, "_unf"}, 32'(unf), 32'(e.unf));
      chk({e.tag, "_full"}, 32'(full), 32'(e.cnt == 3'd4));
      chk({e.tag, "_empty"}, 32'(empty), 32'(e.cnt == 3'd0));
    end
  endtask

  initial begin
    #12;
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_dout", 32'(Dout), 32'd0);
    chk("rst_dv", 32'(dvalid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_flags", 32'({ovf, unf}), 32'd0);
    rst = 1'b1;

    //   tag       pu po to cl din      dout     dv cnt ovf unf
    step("push1", 1, 0, 0, 0, 16'h0001, 16'h0000, 0, 1, 0, 0);
    step("push2", 1, 0, 0, 0, 16'h0002, 16'h0000, 0, 2, 0, 0);
    step("push3", 1, 0, 0, 0, 16'h0003, 16'h0000, 0, 3, 0, 0);
    step("push4", 1, 0, 0, 0, 16'h0004, 16'h0000, 0, 4, 0, 0);
    step("push5", 1, 0, 0, 0, 16'h0005, 16'h0000, 0, 4, 1, 0);
    step("tosful", 0, 0, 1, 0, 16'h0000, 16'h0004, 1, 4, 1, 0);
    step("pop4", 0, 1, 0, 0, 16'h0000, 16'h0004, 1, 3, 1, 0);
    step("pop3", 0, 1, 0, 0, 16'h0000, 16'h0003, 1, 2, 1, 0);
    step("pop2", 0, 1, 0, 0, 16'h0000, 16'h0002, 1, 1, 1, 0);
    step("pop1", 0, 1, 0, 0, 16'h0000, 16'h0001, 1, 0, 1, 0);
    step("popunf", 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 0, 1, 1);
    step("idle", 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 1, 1);

    step("pushaa", 1, 0, 0, 0, 16'h00AA, 16'h0001, 0, 1, 1, 1);
    step("tos1", 0, 0, 1, 0, 16'h0000, 16'h00AA, 1, 1, 1, 1);
    step("tos2", 0, 0, 1, 0, 16'h0000, 16'h00AA, 1, 1, 1, 1);
    step("replbb", 1, 1, 0, 0, 16'h00BB, 16'h00AA, 1, 1, 1, 1);
    step("popbb", 0, 1, 0, 0, 16'h0000, 16'h00BB, 1, 0, 1, 1);

    step("clrpush", 1, 0, 0, 1, 16'h00CC, 16'h0000, 0, 0, 0, 0);
    step("replemp", 1, 1, 0, 0, 16'h1234, 16'h0000, 0, 1, 0, 0);
    step("tos1234", 0, 0, 1, 0, 16'h0000, 16'h1234, 1, 1, 0, 0);
    step("prio", 1, 1, 1, 0, 16'h4321, 16'h1234, 1, 1, 0, 0);
    step("pop4321", 0, 1, 1, 0, 16'h0000, 16'h4321, 1, 0, 0, 0);

    step("push7a", 1, 0, 0, 0, 16'h0007, 16'h4321, 0, 1, 0, 0);
    step("push7b", 1, 0, 0, 0, 16'h0007, 16'h4321, 0, 2, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_dout", 32'(Dout), 32'd0);
    push = 1'b1;
    Din  = 16'h0055;
    @(posedge clk);
    #1;
    chk("inrst_cnt", 32'(count), 32'd0);
    push = 1'b0;
    rst  = 1'b1;
    step("push9", 1, 0, 0, 0, 16'h0009, 16'h0000, 0, 1, 0, 0);
    step("tos9", 0, 0, 1, 0, 16'h0000, 16'h0009, 1, 1, 0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
